// File: rtl/tick_timer_sched.sv
// Multi-channel countdown timer scheduler sharing one divider tick across NUM_CH channels.
// Optional sticky overrun flags are enabled by defining TICK_TIMER_SCHED_OVERRUN_EN.
module tick_timer_sched #(
    parameter int  NUM_CH    = 4,
    parameter int  CNT_WIDTH = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick_i,
    input  logic                 cmd_valid_i,
    input  logic [1:0]           cmd_op_i,
    input  logic [CH_W-1:0]      cmd_ch_i,
    input  logic [CNT_WIDTH-1:0] cmd_data_i,
    output logic                 cmd_ready_o,
    output logic                 cmd_err_o,
    input  logic [NUM_CH-1:0]    irq_mask_i,
    output logic [NUM_CH-1:0]    active_o,
    output logic [NUM_CH-1:0]    expire_o,
    output logic [NUM_CH-1:0]    pending_o,
`ifdef TICK_TIMER_SCHED_OVERRUN_EN
    output logic [NUM_CH-1:0]    overrun_o,
`endif
    output logic                 irq_o
);

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_START = 2'd1;
    localparam logic [1:0] OP_STOP  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    logic [CNT_WIDTH-1:0] period_r [NUM_CH];
    logic [CNT_WIDTH-1:0] count_r  [NUM_CH];
    logic [NUM_CH-1:0]    mode_r;
    logic [NUM_CH-1:0]    active_r;
    logic [NUM_CH-1:0]    expire_r;
    logic [NUM_CH-1:0]    pending_r;
    logic                 ready_r;
    logic                 err_r;
    logic                 irq_r;

    logic                 cmd_fire;
    logic                 ch_ok;
    logic                 sel_period_zero;
    logic                 cmd_err;
    logic [NUM_CH-1:0]    sel;
    logic [NUM_CH-1:0]    tick_run;
    logic [NUM_CH-1:0]    expire_now;
    logic [NUM_CH-1:0]    clr_mask;

    always_comb begin
        cmd_fire        = cmd_valid_i & ready_r;
        ch_ok           = 32'(cmd_ch_i) < NUM_CH;
        sel_period_zero = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cmd_ch_i == CH_W'(i) && period_r[i] == '0)
                sel_period_zero = 1'b1;
        end
        cmd_err  = cmd_fire & (~ch_ok | (cmd_op_i == OP_START & sel_period_zero));
        clr_mask = (cmd_fire && ch_ok && cmd_op_i == OP_CLEAR) ? cmd_data_i[NUM_CH-1:0] : '0;
        // A channel-targeted command owns the channel this cycle; a coincident tick is dropped.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            sel[i]        = cmd_fire & ch_ok & ~cmd_err & (cmd_op_i != OP_CLEAR)
                            & (cmd_ch_i == CH_W'(i));
            tick_run[i]   = tick_i & active_r[i] & ~sel[i];
            expire_now[i] = tick_run[i] & (count_r[i] <= CNT_WIDTH'(1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_r   <= 1'b0;
            err_r     <= 1'b0;
            irq_r     <= 1'b0;
            mode_r    <= '0;
            active_r  <= '0;
            expire_r  <= '0;
            pending_r <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                period_r[i] <= '0;
                count_r[i]  <= '0;
            end
        end else begin
            ready_r   <= 1'b1;
            err_r     <= cmd_err;
            expire_r  <= expire_now;
            pending_r <= expire_now | (pending_r & ~clr_mask);
            irq_r     <= |(pending_r & irq_mask_i);
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (sel[i]) begin
                    case (cmd_op_i)
                        OP_LOAD:  period_r[i] <= cmd_data_i;
                        OP_START: begin
                            count_r[i]  <= period_r[i];
                            mode_r[i]   <= cmd_data_i[0];
                            active_r[i] <= 1'b1;
                        end
                        OP_STOP:  active_r[i] <= 1'b0;
                        default:  ;
                    endcase
                end else if (tick_run[i]) begin
                    if (expire_now[i]) begin
                        if (mode_r[i])
                            count_r[i] <= period_r[i];
                        else
                            active_r[i] <= 1'b0;
                    end else begin
                        count_r[i] <= count_r[i] - CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

`ifdef TICK_TIMER_SCHED_OVERRUN_EN
    logic [NUM_CH-1:0] overrun_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overrun_r <= '0;
        else
            overrun_r <= (expire_now & pending_r) | (overrun_r & ~clr_mask);
    end

    assign overrun_o = overrun_r;
`endif

    assign cmd_ready_o = ready_r;
    assign cmd_err_o   = err_r;
    assign active_o    = active_r;
    assign expire_o    = expire_r;
    assign pending_o   = pending_r;
    assign irq_o       = irq_r;

endmodule

// File: tb/tb_tick_timer_sched.sv
// Self-checking bench for tick_timer_sched: 4-channel main instance plus a 3-channel
// instance for the out-of-range channel case.
module tb_tick_timer_sched;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_START = 2'd1;
    localparam logic [1:0] OP_STOP  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tick_i;
    logic        cmd_valid_i;
    logic [1:0]  cmd_op_i;
    logic [1:0]  cmd_ch_i;
    logic [15:0] cmd_data_i;
    logic        cmd_ready_o;
    logic        cmd_err_o;
    logic [3:0]  irq_mask_i;
    logic [3:0]  active_o;
    logic [3:0]  expire_o;
    logic [3:0]  pending_o;
    logic        irq_o;

    logic        c3_valid;
    logic [1:0]  c3_op;
    logic [1:0]  c3_ch;
    logic [15:0] c3_data;
    logic        c3_ready;
    logic        c3_err;
    logic [2:0]  c3_active;
    logic [2:0]  c3_expire;
    logic [2:0]  c3_pending;
    logic        c3_irq;
`ifdef TICK_TIMER_SCHED_OVERRUN_EN
    logic [3:0]  overrun_o;
    logic [2:0]  c3_overrun;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  e;

    always #5 clk = ~clk;

    tick_timer_sched #(.NUM_CH(4), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .tick_i(tick_i),
        .cmd_valid_i(cmd_valid_i), .cmd_op_i(cmd_op_i), .cmd_ch_i(cmd_ch_i),
        .cmd_data_i(cmd_data_i), .cmd_ready_o(cmd_ready_o), .cmd_err_o(cmd_err_o),
        .irq_mask_i(irq_mask_i), .active_o(active_o), .expire_o(expire_o),
        .pending_o(pending_o),
`ifdef TICK_TIMER_SCHED_OVERRUN_EN
        .overrun_o(overrun_o),
`endif
        .irq_o(irq_o)
    );

    tick_timer_sched #(.NUM_CH(3), .CNT_WIDTH(16)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .tick_i(tick_i),
        .cmd_valid_i(c3_valid), .cmd_op_i(c3_op), .cmd_ch_i(c3_ch),
        .cmd_data_i(c3_data), .cmd_ready_o(c3_ready), .cmd_err_o(c3_err),
        .irq_mask_i(3'b000), .active_o(c3_active), .expire_o(c3_expire),
        .pending_o(c3_pending),
`ifdef TICK_TIMER_SCHED_OVERRUN_EN
        .overrun_o(c3_overrun),
`endif
        .irq_o(c3_irq)
    );

    task automatic send(input logic [1:0] op, input logic [1:0] ch, input logic [15:0] d);
        cmd_valid_i = 1'b1; cmd_op_i = op; cmd_ch_i = ch; cmd_data_i = d;
        @(negedge clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic send3(input logic [1:0] op, input logic [1:0] ch, input logic [15:0] d);
        c3_valid = 1'b1; c3_op = op; c3_ch = ch; c3_data = d;
        @(negedge clk);
        c3_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (cmd_ready_o !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", cmd_ready_o); end
        n_cmp++; if ({active_o, expire_o, pending_o} !== 12'h000) begin n_bad++; $display("FAIL reset_state: got %h want 000", {active_o, expire_o, pending_o}); end
        n_cmp++; if ({irq_o, cmd_err_o} !== 2'b00) begin n_bad++; $display("FAIL reset_irq_err: got %b want 00", {irq_o, cmd_err_o}); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (cmd_ready_o !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b want 1", cmd_ready_o); end
        n_cmp++; if (c3_ready !== 1'b1) begin n_bad++; $display("FAIL ready3_after_reset: got %b want 1", c3_ready); end
    endtask

    task automatic test_periodic();
        int nt = 0;
        send(OP_LOAD, 2'd0, 16'd3);
        send(OP_START, 2'd0, 16'd1);
        n_cmp++; if (active_o !== 4'b0001) begin n_bad++; $display("FAIL per_active_start: got %b want 0001", active_o); end
        for (int k = 0; k < 36; k++) begin
            tick_i = (k % 4 == 0);
            if (tick_i) nt++;
            exp_q.push_back((tick_i && nt % 3 == 0) ? 4'b0001 : 4'b0000);
            @(negedge clk);
            tick_i = 1'b0;
            e = exp_q.pop_front();
            n_cmp++; if (expire_o !== e) begin n_bad++; $display("FAIL per_expire k=%0d: got %b want %b", k, expire_o, e); end
        end
        n_cmp++; if (active_o !== 4'b0001) begin n_bad++; $display("FAIL per_active_end: got %b want 0001", active_o); end
        n_cmp++; if (pending_o !== 4'b0001) begin n_bad++; $display("FAIL per_pending: got %b want 0001", pending_o); end
        n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL per_irq_masked: got %b want 0", irq_o); end
        send(OP_STOP, 2'd0, 16'd0);
        send(OP_CLEAR, 2'd0, 16'h000f);
        n_cmp++; if (pending_o !== 4'b0000) begin n_bad++; $display("FAIL per_clear: got %b want 0000", pending_o); end
        n_cmp++; if (active_o !== 4'b0000) begin n_bad++; $display("FAIL per_stop: got %b want 0000", active_o); end
    endtask

    task automatic test_oneshot();
        int nt = 0;
        send(OP_LOAD, 2'd1, 16'd2);
        send(OP_START, 2'd1, 16'd0);
        for (int k = 0; k < 6; k++) begin
            tick_i = 1'b1;
            nt++;
            exp_q.push_back((nt == 2) ? 4'b0010 : 4'b0000);
            @(negedge clk);
            tick_i = 1'b0;
            e = exp_q.pop_front();
            n_cmp++; if (expire_o !== e) begin n_bad++; $display("FAIL one_expire k=%0d: got %b want %b", k, expire_o, e); end
        end
        n_cmp++; if (active_o !== 4'b0000) begin n_bad++; $display("FAIL one_idle: got %b want 0000", active_o); end
        n_cmp++; if (pending_o !== 4'b0010) begin n_bad++; $display("FAIL one_pending: got %b want 0010", pending_o); end
        send(OP_CLEAR, 2'd0, 16'h0002);
    endtask

    task automatic test_load_running();
        send(OP_LOAD, 2'd1, 16'd2);
        send(OP_START, 2'd1, 16'd1);
        tick_i = 1'b1;
        @(negedge clk);
        tick_i = 1'b0;
        n_cmp++; if (expire_o !== 4'b0000) begin n_bad++; $display("FAIL ldrun_first: got %b want 0000", expire_o); end
        send(OP_LOAD, 2'd1, 16'd4);
        for (int j = 0; j < 6; j++) begin
            tick_i = 1'b1;
            exp_q.push_back((j == 0 || j == 4) ? 4'b0010 : 4'b0000);
            @(negedge clk);
            tick_i = 1'b0;
            e = exp_q.pop_front();
            n_cmp++; if (expire_o !== e) begin n_bad++; $display("FAIL ldrun_expire j=%0d: got %b want %b", j, expire_o, e); end
        end
        send(OP_STOP, 2'd1, 16'd0);
        send(OP_CLEAR, 2'd0, 16'h000f);
    endtask

    task automatic test_errors();
        send(OP_START, 2'd2, 16'd1);
        n_cmp++; if (cmd_err_o !== 1'b1) begin n_bad++; $display("FAIL err_zero_period: got %b want 1", cmd_err_o); end
        n_cmp++; if (active_o !== 4'b0000) begin n_bad++; $display("FAIL err_state: got %b want 0000", active_o); end
        @(negedge clk);
        n_cmp++; if (cmd_err_o !== 1'b0) begin n_bad++; $display("FAIL err_one_cycle: got %b want 0", cmd_err_o); end
        send(OP_LOAD, 2'd2, 16'd5);
        n_cmp++; if (cmd_err_o !== 1'b0) begin n_bad++; $display("FAIL err_load_ok: got %b want 0", cmd_err_o); end
        send(OP_STOP, 2'd2, 16'd0);
        n_cmp++; if (cmd_err_o !== 1'b0) begin n_bad++; $display("FAIL err_stop_idle: got %b want 0", cmd_err_o); end
        send3(OP_LOAD, 2'd3, 16'd5);
        n_cmp++; if (c3_err !== 1'b1) begin n_bad++; $display("FAIL err_range_load: got %b want 1", c3_err); end
        send3(OP_START, 2'd3, 16'd1);
        n_cmp++; if (c3_err !== 1'b1) begin n_bad++; $display("FAIL err_range_start: got %b want 1", c3_err); end
        n_cmp++; if (c3_active !== 3'b000) begin n_bad++; $display("FAIL err_range_state: got %b want 000", c3_active); end
        @(negedge clk);
        n_cmp++; if (c3_err !== 1'b0) begin n_bad++; $display("FAIL err_range_pulse: got %b want 0", c3_err); end
        send3(OP_LOAD, 2'd2, 16'd7);
        send3(OP_START, 2'd2, 16'd1);
        n_cmp++; if ({c3_err, c3_active} !== 4'b0100) begin n_bad++; $display("FAIL range_valid_start: got %b want 0100", {c3_err, c3_active}); end
        send3(OP_STOP, 2'd2, 16'd0);
        n_cmp++; if ({c3_active, c3_expire, c3_pending, c3_irq} !== 10'h000) begin n_bad++; $display("FAIL range_quiet: got %h want 000", {c3_active, c3_expire, c3_pending, c3_irq}); end
    endtask

    task automatic test_clear_irq();
        send(OP_LOAD, 2'd3, 16'd1);
        send(OP_START, 2'd3, 16'd1);
        tick_i = 1'b1;
        @(negedge clk);
        tick_i = 1'b0;
        n_cmp++; if ({expire_o, pending_o} !== 8'h88) begin n_bad++; $display("FAIL coll_first: got %h want 88", {expire_o, pending_o}); end
        tick_i = 1'b1;
        cmd_valid_i = 1'b1; cmd_op_i = OP_CLEAR; cmd_ch_i = 2'd0; cmd_data_i = 16'h0008;
        @(negedge clk);
        tick_i = 1'b0;
        cmd_valid_i = 1'b0;
        n_cmp++; if ({expire_o, pending_o} !== 8'h88) begin n_bad++; $display("FAIL coll_set_wins: got %h want 88", {expire_o, pending_o}); end
        n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL irq_masked: got %b want 0", irq_o); end
        irq_mask_i = 4'b1000;
        @(negedge clk);
        n_cmp++; if (irq_o !== 1'b1) begin n_bad++; $display("FAIL irq_unmask: got %b want 1", irq_o); end
        send(OP_STOP, 2'd3, 16'd0);
        send(OP_CLEAR, 2'd0, 16'h000f);
        n_cmp++; if (pending_o !== 4'b0000) begin n_bad++; $display("FAIL irq_clear_pending: got %b want 0000", pending_o); end
        @(negedge clk);
        n_cmp++; if (irq_o !== 1'b0) begin n_bad++; $display("FAIL irq_drop: got %b want 0", irq_o); end
        send(OP_START, 2'd3, 16'd0);
        tick_i = 1'b1;
        @(negedge clk);
        tick_i = 1'b0;
        n_cmp++; if ({expire_o, irq_o} !== 5'b10000) begin n_bad++; $display("FAIL irq_lat1: got %b want 10000", {expire_o, irq_o}); end
        @(negedge clk);
        n_cmp++; if ({active_o, irq_o} !== 5'b00001) begin n_bad++; $display("FAIL irq_lat2: got %b want 00001", {active_o, irq_o}); end
        send(OP_CLEAR, 2'd0, 16'h000f);
        irq_mask_i = 4'b0000;
        @(negedge clk);
    endtask

`ifdef TICK_TIMER_SCHED_OVERRUN_EN
    task automatic test_overrun();
        send(OP_LOAD, 2'd0, 16'd1);
        send(OP_START, 2'd0, 16'd1);
        tick_i = 1'b1;
        @(negedge clk);
        n_cmp++; if ({pending_o[0], overrun_o[0]} !== 2'b10) begin n_bad++; $display("FAIL ovr_first: got %b want 10", {pending_o[0], overrun_o[0]}); end
        @(negedge clk);
        tick_i = 1'b0;
        n_cmp++; if (overrun_o[0] !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b want 1", overrun_o[0]); end
        send(OP_STOP, 2'd0, 16'd0);
        send(OP_CLEAR, 2'd0, 16'h0001);
        n_cmp++; if ({pending_o[0], overrun_o[0]} !== 2'b00) begin n_bad++; $display("FAIL ovr_clear: got %b want 00", {pending_o[0], overrun_o[0]}); end
    endtask
`endif

    task automatic test_reset_midrun();
        int nt = 0;
        irq_mask_i = 4'b0001;
        send(OP_LOAD, 2'd0, 16'd3);
        send(OP_START, 2'd0, 16'd1);
        for (int k = 0; k < 4; k++) begin
            tick_i = 1'b1;
            nt++;
            exp_q.push_back((nt == 3) ? 4'b0001 : 4'b0000);
            @(negedge clk);
            tick_i = 1'b0;
            e = exp_q.pop_front();
            n_cmp++; if (expire_o !== e) begin n_bad++; $display("FAIL mid_expire k=%0d: got %b want %b", k, expire_o, e); end
        end
        n_cmp++; if ({active_o[0], irq_o} !== 2'b11) begin n_bad++; $display("FAIL mid_before: got %b want 11", {active_o[0], irq_o}); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if ({active_o, expire_o, pending_o, irq_o, cmd_err_o, cmd_ready_o} !== 15'h0000) begin n_bad++; $display("FAIL mid_async_clear: got %h want 0000", {active_o, expire_o, pending_o, irq_o, cmd_err_o, cmd_ready_o}); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (cmd_ready_o !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", cmd_ready_o); end
        for (int k = 0; k < 8; k++) begin
            tick_i = 1'b1;
            exp_q.push_back(4'b0000);
            @(negedge clk);
            tick_i = 1'b0;
            e = exp_q.pop_front();
            n_cmp++; if ({active_o, expire_o} !== {4'b0000, e}) begin n_bad++; $display("FAIL mid_quiet k=%0d: got %h want %h", k, {active_o, expire_o}, {4'b0000, e}); end
        end
        n_cmp++; if (pending_o !== 4'b0000) begin n_bad++; $display("FAIL mid_pending: got %b want 0000", pending_o); end
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish, mismatches %0d", n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n     = 1'b1;
        tick_i      = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 2'd0;
        cmd_ch_i    = 2'd0;
        cmd_data_i  = 16'd0;
        irq_mask_i  = 4'b0000;
        c3_valid    = 1'b0;
        c3_op       = 2'd0;
        c3_ch       = 2'd0;
        c3_data     = 16'd0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_load_running();
        test_errors();
        test_clear_irq();
`ifdef TICK_TIMER_SCHED_OVERRUN_EN
        test_overrun();
`endif
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
